// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide controller.
package muldiv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/div_core.sv
// Restoring unsigned divider: one quotient bit per step, operands loaded as magnitudes.
module div_core
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // Bit XLEN of the trial difference is the borrow: set means restore.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
    end else if (step_i) begin
      if (!trial[XLEN]) begin
        rem_d = trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS-style HI/LO controller: MTHI/MTLO, 2-cycle multiply, 32-iteration divide.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  input  logic [XLEN-1:0] hi_rdata,
  input  logic [XLEN-1:0] lo_rdata,
  output logic            stall_o,
  output logic            busy,
  output logic            hilo_we,
  output logic [XLEN-1:0] hi_wdata,
  output logic [XLEN-1:0] lo_wdata
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              sgn_q, sgn_d;
  logic              isdiv_q, isdiv_d;
  logic [2*XLEN-1:0] prod_q, prod_d;

  logic              div_load;
  logic              div_step;
  logic [XLEN-1:0]   div_quo;
  logic [XLEN-1:0]   div_rem;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic              neg_quo;
  logic              neg_rem;

  // Magnitudes feed the divider; only signed DIV folds negative operands.
  assign mag_a   = (op == OP_DIV && src_a[XLEN-1]) ? -src_a : src_a;
  assign mag_b   = (op == OP_DIV && src_b[XLEN-1]) ? -src_b : src_b;
  assign a_ext   = {{XLEN{sgn_q & a_q[XLEN-1]}}, a_q};
  assign b_ext   = {{XLEN{sgn_q & b_q[XLEN-1]}}, b_q};
  assign neg_quo = sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign neg_rem = sgn_q & a_q[XLEN-1];
  assign busy    = (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    isdiv_d  = isdiv_q;
    prod_d   = prod_q;
    div_load = 1'b0;
    div_step = 1'b0;
    stall_o  = 1'b0;
    hilo_we  = 1'b0;
    hi_wdata = '0;
    lo_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              a_d     = src_a;
              b_d     = src_b;
              sgn_d   = (op == OP_MULT);
              isdiv_d = 1'b0;
              stall_o = 1'b1;
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d      = src_a;
              b_d      = src_b;
              sgn_d    = (op == OP_DIV);
              isdiv_d  = 1'b1;
              cnt_d    = '0;
              div_load = 1'b1;
              stall_o  = 1'b1;
              state_d  = S_DIV_RUN;
            end
            OP_MTHI: begin
              hilo_we  = 1'b1;
              hi_wdata = src_a;
              lo_wdata = lo_rdata;
            end
            OP_MTLO: begin
              hilo_we  = 1'b1;
              hi_wdata = hi_rdata;
              lo_wdata = src_a;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        stall_o = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          prod_d  = a_ext * b_ext;
          state_d = S_DONE;
        end
      end
      S_DIV_RUN: begin
        stall_o = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          div_step = 1'b1;
          if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!flush) begin
          hilo_we = 1'b1;
          if (!isdiv_q) begin
            hi_wdata = prod_q[2*XLEN-1:XLEN];
            lo_wdata = prod_q[XLEN-1:0];
          end else if (b_q == '0) begin
            // Divide by zero reports all-ones quotient and the raw dividend.
            hi_wdata = a_q;
            lo_wdata = '1;
          end else begin
            hi_wdata = neg_rem ? -div_rem : div_rem;
            lo_wdata = neg_quo ? -div_quo : div_quo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      isdiv_q <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      isdiv_q <= isdiv_d;
      prod_q  <= prod_d;
    end
  end

  div_core u_div_core (
    .clk         (clk),
    .rst         (rst),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (mag_a),
    .divisor_i   (mag_b),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table plus flush/reset corner sequences.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;
  logic        stall_o;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  muldiv_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata),
    .stall_o  (stall_o),
    .busy     (busy),
    .hilo_we  (hilo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
    string       name;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hr;
    logic [31:0] lr;
    logic [31:0] eh;
    logic [31:0] el;
    int          lat;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   unexpected = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Every HI/LO write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (hilo_we === 1'b1) begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, " hi"}, 64'(hi_wdata), 64'(e.hi));
        check({e.name, " lo"}, 64'(lo_wdata), 64'(e.lo));
        check({e.name, " cycle"}, 64'(cyc), 64'(e.due));
      end else begin
        unexpected++;
        $display("FAIL unexpected write: hi=%h lo=%h at cycle %0d", hi_wdata, lo_wdata, cyc);
      end
    end
  end

  task automatic run_op(input string name, input vec_t v);
    int stalls;
    stalls = 0;
    @(posedge clk); #1;
    start = 1'b1; op = v.op; src_a = v.a; src_b = v.b;
    hi_rdata = v.hr; lo_rdata = v.lr;
    if (v.lat >= 0) exp_q.push_back('{v.eh, v.el, cyc + v.lat, name});
    @(negedge clk);
    if (stall_o) stalls++;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
      if (exp_q.size() == 0 && !busy) break;
      @(negedge clk);
      if (stall_o) stalls++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL %s timeout: %0d writes outstanding, required 0", name, exp_q.size());
      total++;
      exp_q.delete();
    end
    check({name, " stall cycles"}, 64'(stalls), 64'((v.lat > 0) ? v.lat : 0));
  endtask

  initial begin
    vec_t v;
    int acc;
    rst = 1'b1; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    flush = 1'b0; hi_rdata = '0; lo_rdata = '0;

    vecs.push_back('{3'd1, 32'hFFFFFFFE, 32'h00000003, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 2});
    vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h00000001, 2});
    vecs.push_back('{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 32'h3FFFFFFF, 32'h00000001, 2});
    vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'h00000002, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 2});
    vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'h00000002, 0, 0, 32'h00000001, 32'hFFFFFFFE, 2});
    vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 32'h00000000, 2});
    vecs.push_back('{3'd3, 32'hFFFFFFF9, 32'h00000002, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33});
    vecs.push_back('{3'd4, 32'h00000007, 32'h00000000, 0, 0, 32'h00000007, 32'hFFFFFFFF, 33});
    vecs.push_back('{3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h00000000, 32'h80000000, 33});
    vecs.push_back('{3'd3, 32'h00000007, 32'hFFFFFFFE, 0, 0, 32'h00000001, 32'hFFFFFFFD, 33});
    vecs.push_back('{3'd4, 32'hFFFFFFFF, 32'h00000010, 0, 0, 32'h0000000F, 32'h0FFFFFFF, 33});
    vecs.push_back('{3'd3, 32'hFFFFFFF8, 32'h00000000, 0, 0, 32'hFFFFFFF8, 32'hFFFFFFFF, 33});
    vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h80000000, 32'h00000000, 33});
    vecs.push_back('{3'd3, 32'h00000064, 32'h00000007, 0, 0, 32'h00000002, 32'h0000000E, 33});
    vecs.push_back('{3'd5, 32'h12345678, 32'h0, 32'h0, 32'hABCD0000, 32'h12345678, 32'hABCD0000, 0});
    vecs.push_back('{3'd6, 32'hDEADBEEF, 32'h0, 32'h0BADF00D, 32'h5555AAAA, 32'h0BADF00D, 32'hDEADBEEF, 0});
    vecs.push_back('{3'd0, 32'h11111111, 32'h2, 0, 0, 0, 0, -1});
    vecs.push_back('{3'd7, 32'h11111111, 32'h2, 0, 0, 0, 0, -1});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset stall", 64'(stall_o), 64'd0);
    check("reset we", 64'(hilo_we), 64'd0);
    check("reset wdata", {hi_wdata, lo_wdata}, 64'd0);

    for (int i = 0; i < vecs.size(); i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Flush mid-divide, with an ignored start while busy, then a fresh MULT.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd3; src_a = 32'hFFFFFF9C; src_b = 32'd3; acc = cyc;
    @(posedge clk); #1;
    op = 3'd5; src_a = 32'hCAFEF00D;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("div flush pre busy", 64'(busy), 64'd1);
    check("div flush iteration", 64'(cyc - acc - 1), 64'd10);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("div flush busy", 64'(busy), 64'd0);
    check("div flush stall", 64'(stall_o), 64'd0);
    v = '{3'd1, 32'd5, 32'd6, 0, 0, 32'd0, 32'd30, 2};
    run_op("mult after flush", v);

    // Flush while idle must block acceptance.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 3'd1; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    check("idle flush stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle flush busy", 64'(busy), 64'd0);

    // Flush in DONE suppresses the write.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd2; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    check("done flush busy", 64'(busy), 64'd1);
    check("done flush stall", 64'(stall_o), 64'd0);
    check("done flush we", 64'(hilo_we), 64'd0);
    check("done flush wdata", {hi_wdata, lo_wdata}, 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("done flush idle", 64'(busy), 64'd0);

    // Reset during DIVU iteration 20 aborts with no write.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; src_a = 32'd1000; src_b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst abort busy", 64'(busy), 64'd0);
    check("rst abort we", 64'(hilo_we), 64'd0);
    check("rst abort stall", 64'(stall_o), 64'd0);
    repeat (40) @(posedge clk);

    v = '{3'd4, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 33};
    run_op("divu after reset", v);

    check("no stray writes", 64'(unexpected), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
